icb_wdt: RTL

//  Watchdog timer, ICB slave on crossbar port s5. Down-counts from a programmable load value; software must kick it before expiry.

---
 rtl/icb_wdt.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/icb_wdt.sv
// icb_wdt: watchdog timer with an ICB slave register port.
// The counter reloads from LOAD and counts down while enabled. Software
// must write the kick key to KICK before the counter expires. The first
// expiry sets STATUS.TO, which raises the interrupt if IRQ_EN is set. An
// expiry while TO is still set issues a RST_HOLD-cycle reset request.
// Optional build macro: WDT_LOCK_EN adds the LOCK register at offset 0x18.
//
// ICB handshake: the slave accepts a command on any cycle where
// cmd_valid & cmd_ready. cmd_ready = ~rsp_valid | rsp_ready, so only one
// transaction is ever outstanding. rsp_valid rises on the cycle after
// acceptance. rsp_valid, rsp_rdata and rsp_err stay unchanged until a cycle
// where rsp_valid & rsp_ready. A new command can be accepted in that same
// cycle, which allows one transaction per cycle.
module icb_wdt #(
   parameter logic [31:0] LOAD_INIT = 32'hFFFF_FFFF,
   parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5,
   parameter int unsigned RST_HOLD  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wdt_icb_cmd_valid,
   output logic        wdt_icb_cmd_ready,
   input  logic [31:0] wdt_icb_cmd_addr,
   input  logic        wdt_icb_cmd_read,
   input  logic [31:0] wdt_icb_cmd_wdata,
   input  logic [3:0]  wdt_icb_cmd_wmask,
   output logic        wdt_icb_rsp_valid,
   input  logic        wdt_icb_rsp_ready,
   output logic        wdt_icb_rsp_err,
   output logic [31:0] wdt_icb_rsp_rdata,
   output logic        irq_wdt_o,
   output logic        wdt_rst_o
);

   localparam int HW = $clog2(RST_HOLD + 1);

   // register state
   logic          ctrl_en, ctrl_irq_en, ctrl_rst_en;
   logic [31:0]   load_q;
   logic [31:0]   count_q;
   logic          to_q;
   logic          rst_busy;
   logic [HW-1:0] hold_cnt;

   // decoded command and events
   logic          cmd_acc, wr_acc;
   logic [2:0]    off;
   logic          unmapped;
   logic          wr_ok;
   logic          ctrl_wr, load_wr, kick, to_w1c, en_rise, expire, start_pulse;
   logic [31:0]   load_next;
   logic [31:0]   rd_data;
   logic          unused_addr;

   assign wdt_icb_cmd_ready = ~wdt_icb_rsp_valid | wdt_icb_rsp_ready;
   assign cmd_acc = wdt_icb_cmd_valid & wdt_icb_cmd_ready;
   assign wr_acc  = cmd_acc & ~wdt_icb_cmd_read;
   assign off     = wdt_icb_cmd_addr[4:2];
   assign unused_addr = ^{wdt_icb_cmd_addr[31:5], wdt_icb_cmd_addr[1:0]};

`ifdef WDT_LOCK_EN
   assign unmapped = (off == 3'd5) || (off == 3'd7);
`else
   assign unmapped = (off == 3'd5) || (off == 3'd6) || (off == 3'd7);
`endif

   assign ctrl_wr = wr_acc && (off == 3'd0) && wdt_icb_cmd_wmask[0] && wr_ok;
   assign load_wr = wr_acc && (off == 3'd1) && wr_ok;
   assign kick    = wr_acc && (off == 3'd3) && (wdt_icb_cmd_wmask == 4'hF)
                    && (wdt_icb_cmd_wdata == KICK_KEY);
   assign to_w1c  = wr_acc && (off == 3'd4) && wdt_icb_cmd_wmask[0]
                    && wdt_icb_cmd_wdata[0];
   assign en_rise = ctrl_wr && wdt_icb_cmd_wdata[0] && !ctrl_en;
   // A kick landing on the zero cycle wins, so no expiry occurs
   assign expire      = ctrl_en && (count_q == 32'd0) && !kick;
   assign start_pulse = expire && to_q && ctrl_rst_en && !rst_busy;

   assign irq_wdt_o = to_q & ctrl_irq_en;
   assign wdt_rst_o = rst_busy;

`ifdef WDT_LOCK_EN
   logic locked, unlock_pend;
   assign wr_ok = ~locked | unlock_pend;

   // Lock: set when EN is written as 1. A key written to LOCK opens exactly one accepted transaction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         locked      <= 1'b0;
         unlock_pend <= 1'b0;
      end else begin
         if (cmd_acc)
            unlock_pend <= wr_acc && (off == 3'd6) && (wdt_icb_cmd_wmask == 4'hF)
                           && (wdt_icb_cmd_wdata == KICK_KEY);
         if (ctrl_wr && wdt_icb_cmd_wdata[0])
            locked <= 1'b1;
      end
   end
`else
   assign wr_ok = 1'b1;
`endif

   // Byte-masked merge of the write data into LOAD
   always_comb begin
      load_next = load_q;
      for (int i = 0; i < 4; i++) begin
         if (wdt_icb_cmd_wmask[i])
            load_next[8*i +: 8] = wdt_icb_cmd_wdata[8*i +: 8];
      end
   end

   // Read data mux, sampled in the accept cycle
   always_comb begin
      rd_data = 32'd0;
      case (off)
         3'd0:    rd_data = {29'd0, ctrl_rst_en, ctrl_irq_en, ctrl_en};
         3'd1:    rd_data = load_q;
         3'd2:    rd_data = count_q;
         3'd4:    rd_data = {30'd0, rst_busy, to_q};
         default: rd_data = 32'd0;
      endcase
   end

   // CTRL register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_en     <= 1'b0;
         ctrl_irq_en <= 1'b0;
         ctrl_rst_en <= 1'b0;
      end else if (ctrl_wr) begin
         ctrl_en     <= wdt_icb_cmd_wdata[0];
         ctrl_irq_en <= wdt_icb_cmd_wdata[1];
         ctrl_rst_en <= wdt_icb_cmd_wdata[2];
      end
   end

   // LOAD register. A write here does not reach COUNT until the next reload.
   always_ff @(posedge clk) begin
      if (!rst_n)
         load_q <= LOAD_INIT;
      else if (load_wr)
         load_q <= load_next;
   end

   // Down-counter: reload on kick, on EN rising, or on expiry. Otherwise decrement while enabled.
   always_ff @(posedge clk) begin
      if (!rst_n)
         count_q <= LOAD_INIT;
      else if (kick || en_rise)
         count_q <= load_q;
      else if (ctrl_en) begin
         if (count_q == 32'd0)
            count_q <= load_q;
         else
            count_q <= count_q - 32'd1;
      end
   end

   // Timeout flag. If an expiry and a clear land in the same cycle, the flag stays set.
   always_ff @(posedge clk) begin
      if (!rst_n)
         to_q <= 1'b0;
      else if (expire)
         to_q <= 1'b1;
      else if (to_w1c)
         to_q <= 1'b0;
   end

   // Reset-request pulse. It lasts RST_HOLD cycles and ignores any expiry while it runs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst_busy <= 1'b0;
         hold_cnt <= '0;
      end else if (start_pulse) begin
         rst_busy <= 1'b1;
         hold_cnt <= HW'(RST_HOLD);
      end else if (rst_busy) begin
         hold_cnt <= hold_cnt - HW'(1);
         if (hold_cnt == HW'(1))
            rst_busy <= 1'b0;
      end
   end

   // ICB response channel: capture on accept, hold until consumed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wdt_icb_rsp_valid <= 1'b0;
         wdt_icb_rsp_err   <= 1'b0;
         wdt_icb_rsp_rdata <= 32'd0;
      end else if (cmd_acc) begin
         wdt_icb_rsp_valid <= 1'b1;
         wdt_icb_rsp_err   <= unmapped;
         wdt_icb_rsp_rdata <= (wdt_icb_cmd_read && !unmapped) ? rd_data : 32'd0;
      end else if (wdt_icb_rsp_ready) begin
         wdt_icb_rsp_valid <= 1'b0;
      end
   end

endmodule
